irq_entry_ctrl: RTL
===================

Name: irq_entry_ctrl

Overview:
- Interrupt-entry sequencer for the multi-cycle ARM-style CPU. It is the entry side of the exception protocol whose exit is the MOVS return sequence.
- Arbitrates masked interrupt sources and waits for an instruction boundary from the main control FSM. It then performs the entry writes in order: LR, SPSR, CPSR, PC.
- Tracks the in-service source until the control unit signals return completion.

Parameters:
- N_SRC, 4, number of interrupt sources; index 0 has the highest priority.
- VEC_BASE, 32'h0000_0018, vector address of source 0.
- VEC_STRIDE, 4, byte spacing between per-source vectors.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- irq_req  in  N_SRC  level interrupt requests
- irq_mask  in  N_SRC  1 = source masked
- inst_boundary  in  1  one-cycle pulse from the control FSM when it enters fetch (S0)
- irq_ret  in  1  one-cycle pulse when the MOVS return sequence completes
- pc_cur  in  32  current PC
- cpsr_cur  in  32  current CPSR
- irq_take  out  1  tells the control FSM to hold fetch; high from acceptance through LOAD_PC
- write_lr  out  1  LR_irq write strobe
- lr_data  out  32  value for LR_irq
- write_spsr  out  1  SPSR write strobe
- spsr_data  out  32  value for SPSR
- write_cpsr  out  1  CPSR write strobe
- cpsr_data  out  32  value for CPSR
- write_pc  out  1  PC write strobe
- pc_data  out  32  value for PC
- irq_ack  out  N_SRC  one-hot acknowledge pulse
- in_service  out  N_SRC  one-hot; set while the handler runs
- state  out  3  current FSM state, for debug

Behaviour:
- Reset, asynchronous: state=IDLE, in_service=0, latched index=0. Every strobe, irq_ack and irq_take are 0. All data outputs are 0.
- pending = irq_req & ~irq_mask. The winner is the lowest set index of pending.
- Accept condition: pending != 0, cpsr_cur[7] == 0 (I bit clear), and in_service == 0. No nesting.
- FSM encoding: IDLE=0, PEND=1, SAVE_LR=2, SAVE_SPSR=3, SET_CPSR=4, LOAD_PC=5, ACK=6.
- IDLE: on accept, latch the winner index and go to PEND. Otherwise stay in IDLE.
- PEND: irq_take=1. Stay in PEND until inst_boundary=1, then go to SAVE_LR.
  - The request is committed once latched: withdrawal or masking of the source during PEND does not cancel it.
  - A higher-priority request arriving during PEND does not replace the latched index.
- SAVE_LR: write_lr=1, lr_data=pc_cur+4 (mod 2^32). Next state SAVE_SPSR.
- SAVE_SPSR: write_spsr=1, spsr_data=cpsr_cur. Next state SET_CPSR.
- SET_CPSR: write_cpsr=1. cpsr_data = {cpsr_cur[31:8], 1'b1, cpsr_cur[6:5], 5'b10010}, i.e. I bit set and IRQ mode. Next state LOAD_PC.
- LOAD_PC: write_pc=1, pc_data = VEC_BASE + index*VEC_STRIDE, 32-bit truncated. Next state ACK.
- ACK: irq_ack[index]=1 for exactly one cycle; in_service[index] is set at the end of the cycle. irq_take=0. Next state IDLE.
- Strobes and data are Moore outputs decoded from the current state. Each strobe is high for exactly one cycle, and data outputs are 0 when their strobe is low.
- Latency: inst_boundary seen in PEND at cycle t gives write_lr at t+1, write_pc at t+4 and irq_ack at t+5.
- Earliest re-entry: a new request can be accepted in the cycle after in_service clears, provided cpsr_cur[7]==0.
- irq_ret:
  - in_service != 0: in_service clears on the next edge.
  - in_service == 0: ignored.
  - Coincident with ACK: the set wins.
- Simultaneous requests: only the lowest index is taken. Others stay pending and are re-arbitrated after return.
- inst_boundary outside PEND: ignored.
- Reset mid-sequence: immediate return to IDLE with all outputs cleared. Partially completed writes are not undone.

Test Plan:
- Single IRQ: irq_req=4'b0100, mask=0, cpsr_cur=32'h10, pc_cur=32'h100, inst_boundary 3 cycles later. Required: lr_data=32'h104, spsr_data=32'h10, cpsr_data=32'h92, pc_data=32'h20, irq_ack=4'b0100, in_service=4'b0100.
- Priority/mask: irq_req=4'b1011, mask=4'b0001. Required: source 1 taken, pc_data=32'h1C. After irq_ret, source 3 is not taken while source 1 is still requesting.
- I-bit block: cpsr_cur=32'h90 with irq_req=4'b0001. Required: state stays IDLE and irq_take=0. Clearing the I bit leads to PEND on the next cycle.
- Withdrawal in PEND: accept source 2, drop irq_req before inst_boundary. Required: full sequence still completes with irq_ack=4'b0100.
- Return/re-entry: irq_ret while in_service=4'b0001 with irq_req[0] still high. Required: in_service=0 after one edge, then a new PEND one cycle later. irq_ret with in_service=0 produces no change.
- Async reset in SET_CPSR: rst pulse mid-cycle. Required: state=0, all strobes 0 and in_service=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_entry_ctrl.sv
// Interrupt-entry sequencer: arbitrates masked sources, waits for an instruction
// boundary, then issues LR, SPSR, CPSR and PC writes before acknowledging the source.
module irq_entry_ctrl #(
  parameter int          N_SRC      = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0018,
  parameter int          VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_req,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             inst_boundary,
  input  logic             irq_ret,
  input  logic [31:0]      pc_cur,
  input  logic [31:0]      cpsr_cur,
  output logic             irq_take,
  output logic             write_lr,
  output logic [31:0]      lr_data,
  output logic             write_spsr,
  output logic [31:0]      spsr_data,
  output logic             write_cpsr,
  output logic [31:0]      cpsr_data,
  output logic             write_pc,
  output logic [31:0]      pc_data,
  output logic [N_SRC-1:0] irq_ack,
  output logic [N_SRC-1:0] in_service,
  output logic [2:0]       state
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PEND      = 3'd1,
    SAVE_LR   = 3'd2,
    SAVE_SPSR = 3'd3,
    SET_CPSR  = 3'd4,
    LOAD_PC   = 3'd5,
    ACK       = 3'd6
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic             r_take;
  logic             r_wlr;
  logic             r_wspsr;
  logic             r_wcpsr;
  logic             r_wpc;
  logic [N_SRC-1:0] r_ack;
  logic [N_SRC-1:0] r_in_service;

  logic [N_SRC-1:0] w_pending;
  logic [IW-1:0]    w_win;
  logic             w_accept;
  logic [N_SRC-1:0] w_idx_onehot;
  logic [31:0]      w_vec;

  assign w_pending = irq_req & ~irq_mask;

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    w_win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_pending[i]) w_win = IW'(i);
    end
  end

  // No nesting: a new entry needs the I bit clear and nothing in service.
  assign w_accept     = (|w_pending) && !cpsr_cur[7] && !(|r_in_service);
  assign w_idx_onehot = {{(N_SRC-1){1'b0}}, 1'b1} << r_idx;
  assign w_vec        = VEC_BASE + (32'(r_idx) * 32'(VEC_STRIDE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_take       <= 1'b0;
      r_wlr        <= 1'b0;
      r_wspsr      <= 1'b0;
      r_wcpsr      <= 1'b0;
      r_wpc        <= 1'b0;
      r_ack        <= '0;
      r_in_service <= '0;
    end else begin
      r_wlr   <= 1'b0;
      r_wspsr <= 1'b0;
      r_wcpsr <= 1'b0;
      r_wpc   <= 1'b0;
      r_ack   <= '0;

      // The set in ACK takes precedence over a coincident return.
      if (r_state == ACK)
        r_in_service <= w_idx_onehot;
      else if (irq_ret && (|r_in_service))
        r_in_service <= '0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx   <= w_win;
            r_state <= PEND;
            r_take  <= 1'b1;
          end
        end
        PEND: begin
          if (inst_boundary) begin
            r_state <= SAVE_LR;
            r_wlr   <= 1'b1;
          end
        end
        SAVE_LR: begin
          r_state <= SAVE_SPSR;
          r_wspsr <= 1'b1;
        end
        SAVE_SPSR: begin
          r_state <= SET_CPSR;
          r_wcpsr <= 1'b1;
        end
        SET_CPSR: begin
          r_state <= LOAD_PC;
          r_wpc   <= 1'b1;
        end
        LOAD_PC: begin
          r_state <= ACK;
          r_take  <= 1'b0;
          r_ack   <= w_idx_onehot;
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_take  <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are registered alongside the state; data is gated by its strobe.
  assign irq_take   = r_take;
  assign write_lr   = r_wlr;
  assign write_spsr = r_wspsr;
  assign write_cpsr = r_wcpsr;
  assign write_pc   = r_wpc;
  assign lr_data    = r_wlr   ? (pc_cur + 32'd4) : 32'd0;
  assign spsr_data  = r_wspsr ? cpsr_cur : 32'd0;
  assign cpsr_data  = r_wcpsr ? {cpsr_cur[31:8], 1'b1, cpsr_cur[6:5], 5'b10010} : 32'd0;
  assign pc_data    = r_wpc   ? w_vec : 32'd0;
  assign irq_ack    = r_ack;
  assign in_service = r_in_service;
  assign state      = r_state;

endmodule
